// File: rtl/tts_state_encoder_if.sv
// Status sources into, and TTS code out of, the TTS state encoder.
// master drives the status sources; slave is the encoder itself.
interface tts_state_encoder_if #(
  parameter int FILL_WIDTH = 12
);
  logic                  ttc_ready;
  logic [FILL_WIDTH-1:0] fifo_fill;
  logic                  sync_lost;
  logic                  resync_done;
  logic                  fatal_error;
  logic                  error_clear;
  logic [3:0]            tts_state;
  logic                  tts_changed;
  logic                  error_sticky;

  modport master (
    output ttc_ready, fifo_fill, sync_lost, resync_done, fatal_error, error_clear,
    input  tts_state, tts_changed, error_sticky
  );

  modport slave (
    input  ttc_ready, fifo_fill, sync_lost, resync_done, fatal_error, error_clear,
    output tts_state, tts_changed, error_sticky
  );
endinterface

// File: rtl/tts_state_encoder.sv
// Encodes link, buffer-fill, sync and error status into the 4-bit TTS code,
// with fill hysteresis, sticky error/out-of-sync latches and a minimum dwell.
module tts_state_encoder #(
  parameter int FILL_WIDTH = 12,
  parameter int WARN_ON    = 2048,
  parameter int WARN_OFF   = 1536,
  parameter int BUSY_ON    = 3584,
  parameter int BUSY_OFF   = 3072,
  parameter int MIN_DWELL  = 16
) (
  input logic               clk,
  input logic               rst,
  tts_state_encoder_if.slave bus
);

  typedef enum logic [3:0] {
    TTS_DISC  = 4'b0000,
    TTS_WARN  = 4'b0001,
    TTS_OOS   = 4'b0010,
    TTS_BUSY  = 4'b0100,
    TTS_READY = 4'b1000,
    TTS_ERROR = 4'b1100
  } tts_code_e;

  localparam logic [FILL_WIDTH-1:0] WARN_ON_L  = FILL_WIDTH'(WARN_ON);
  localparam logic [FILL_WIDTH-1:0] WARN_OFF_L = FILL_WIDTH'(WARN_OFF);
  localparam logic [FILL_WIDTH-1:0] BUSY_ON_L  = FILL_WIDTH'(BUSY_ON);
  localparam logic [FILL_WIDTH-1:0] BUSY_OFF_L = FILL_WIDTH'(BUSY_OFF);
  localparam logic [7:0]            DWELL_LOAD = 8'(MIN_DWELL - 1);

  logic                  ttc_ready_r;
  logic [FILL_WIDTH-1:0] fill_r;
  logic                  sync_lost_r;
  logic                  resync_done_r;
  logic                  fatal_error_r;
  logic                  error_clear_r;

  logic                  error_r, oos_r, warn_r, busy_r;
  logic                  error_nx_s, oos_nx_s, warn_nx_s, busy_nx_s;
  logic [7:0]            dwell_r, dwell_nx_s;
  tts_code_e             state_r, state_nx_s, cand_s;
  logic                  changed_r, changed_nx_s;

  // Input stage: every source is registered exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      ttc_ready_r   <= 1'b0;
      fill_r        <= '0;
      sync_lost_r   <= 1'b0;
      resync_done_r <= 1'b0;
      fatal_error_r <= 1'b0;
      error_clear_r <= 1'b0;
    end else begin
      ttc_ready_r   <= bus.ttc_ready;
      fill_r        <= bus.fifo_fill;
      sync_lost_r   <= bus.sync_lost;
      resync_done_r <= bus.resync_done;
      fatal_error_r <= bus.fatal_error;
      error_clear_r <= bus.error_clear;
    end
  end

  // Latch/hysteresis updates, priority candidate and dwell-gated next code.
  always_comb begin
    error_nx_s   = error_r;
    oos_nx_s     = oos_r;
    warn_nx_s    = warn_r;
    busy_nx_s    = busy_r;
    cand_s       = TTS_READY;
    state_nx_s   = state_r;
    dwell_nx_s   = dwell_r;
    changed_nx_s = 1'b0;

    // Set beats clear on both sticky latches.
    if (fatal_error_r) begin
      error_nx_s = 1'b1;
    end else if (error_clear_r) begin
      error_nx_s = 1'b0;
    end else begin
      error_nx_s = error_r;
    end

    if (sync_lost_r) begin
      oos_nx_s = 1'b1;
    end else if (resync_done_r) begin
      oos_nx_s = 1'b0;
    end else begin
      oos_nx_s = oos_r;
    end

    if (fill_r >= WARN_ON_L) begin
      warn_nx_s = 1'b1;
    end else if (fill_r < WARN_OFF_L) begin
      warn_nx_s = 1'b0;
    end else begin
      warn_nx_s = warn_r;
    end

    if (fill_r >= BUSY_ON_L) begin
      busy_nx_s = 1'b1;
    end else if (fill_r < BUSY_OFF_L) begin
      busy_nx_s = 1'b0;
    end else begin
      busy_nx_s = busy_r;
    end

    if (error_nx_s) begin
      cand_s = TTS_ERROR;
    end else if (!ttc_ready_r) begin
      cand_s = TTS_DISC;
    end else if (oos_nx_s) begin
      cand_s = TTS_OOS;
    end else if (busy_nx_s) begin
      cand_s = TTS_BUSY;
    end else if (warn_nx_s) begin
      cand_s = TTS_WARN;
    end else begin
      cand_s = TTS_READY;
    end

    // ERROR pre-empts the dwell; any other change waits for it to run out.
    if ((cand_s != state_r) && ((dwell_r == 8'd0) || (cand_s == TTS_ERROR))) begin
      state_nx_s   = cand_s;
      dwell_nx_s   = DWELL_LOAD;
      changed_nx_s = 1'b1;
    end else if (dwell_r != 8'd0) begin
      dwell_nx_s = dwell_r - 8'd1;
    end else begin
      dwell_nx_s = 8'd0;
    end
  end

  // State register: code, change pulse, latches and dwell counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= TTS_DISC;
      changed_r <= 1'b0;
      error_r   <= 1'b0;
      oos_r     <= 1'b0;
      warn_r    <= 1'b0;
      busy_r    <= 1'b0;
      dwell_r   <= 8'd0;
    end else begin
      state_r   <= state_nx_s;
      changed_r <= changed_nx_s;
      error_r   <= error_nx_s;
      oos_r     <= oos_nx_s;
      warn_r    <= warn_nx_s;
      busy_r    <= busy_nx_s;
      dwell_r   <= dwell_nx_s;
    end
  end

  assign bus.tts_state    = state_r;
  assign bus.tts_changed  = changed_r;
  assign bus.error_sticky = error_r;

endmodule

// File: tb/tb_tts_state_encoder.sv
// Self-checking bench for tts_state_encoder: directed scenarios with fixed
// expectations, then randomized traffic against a rule-level reference model.
module tb_tts_state_encoder;

  localparam int FW        = 12;
  localparam int WARN_ON   = 2048;
  localparam int WARN_OFF  = 1536;
  localparam int BUSY_ON   = 3584;
  localparam int BUSY_OFF  = 3072;
  localparam int MIN_DWELL = 16;

  localparam logic [3:0] C_READY = 4'b1000;
  localparam logic [3:0] C_BUSY  = 4'b0100;
  localparam logic [3:0] C_OOS   = 4'b0010;
  localparam logic [3:0] C_WARN  = 4'b0001;
  localparam logic [3:0] C_ERROR = 4'b1100;
  localparam logic [3:0] C_DISC  = 4'b0000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: rules applied to the inputs seen one cycle earlier.
  logic [3:0] m_state;
  logic       m_changed, m_err, m_oos, m_warn, m_busy;
  logic       q_ttc, q_sync, q_resync, q_fatal, q_clear;
  int         q_fill;
  int         cyc;
  int         last_chg;

  tts_state_encoder_if #(.FILL_WIDTH(FW)) ifc ();

  tts_state_encoder #(
    .FILL_WIDTH(FW), .WARN_ON(WARN_ON), .WARN_OFF(WARN_OFF),
    .BUSY_ON(BUSY_ON), .BUSY_OFF(BUSY_OFF), .MIN_DWELL(MIN_DWELL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    logic [3:0] want;
    @(posedge clk);
    if (rst) begin
      m_state = C_DISC; m_changed = 1'b0; m_err = 1'b0; m_oos = 1'b0;
      m_warn = 1'b0; m_busy = 1'b0; last_chg = -1000;
      q_ttc = 1'b0; q_fill = 0; q_sync = 1'b0; q_resync = 1'b0; q_fatal = 1'b0; q_clear = 1'b0;
    end else begin
      if (q_fatal) m_err = 1'b1; else if (q_clear) m_err = 1'b0;
      if (q_sync) m_oos = 1'b1; else if (q_resync) m_oos = 1'b0;
      if (q_fill >= WARN_ON) m_warn = 1'b1; else if (q_fill < WARN_OFF) m_warn = 1'b0;
      if (q_fill >= BUSY_ON) m_busy = 1'b1; else if (q_fill < BUSY_OFF) m_busy = 1'b0;
      if (m_err) want = C_ERROR;
      else if (!q_ttc) want = C_DISC;
      else if (m_oos) want = C_OOS;
      else if (m_busy) want = C_BUSY;
      else if (m_warn) want = C_WARN;
      else want = C_READY;
      if (want != m_state && (want == C_ERROR || cyc - last_chg >= MIN_DWELL)) begin
        m_state = want; m_changed = 1'b1; last_chg = cyc;
      end else begin
        m_changed = 1'b0;
      end
      q_ttc = ifc.ttc_ready; q_fill = int'(ifc.fifo_fill); q_sync = ifc.sync_lost;
      q_resync = ifc.resync_done; q_fatal = ifc.fatal_error; q_clear = ifc.error_clear;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.ttc_ready = 1'b0; ifc.fifo_fill = '0; ifc.sync_lost = 1'b0;
    ifc.resync_done = 1'b0; ifc.fatal_error = 1'b0; ifc.error_clear = 1'b0;
    repeat (3) begin
      tick();
      checks++; if (ifc.tts_state !== C_DISC) begin errors++; $display("FAIL reset_state: got %b want %b", ifc.tts_state, C_DISC); end
      checks++; if (ifc.tts_changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b want 0", ifc.tts_changed); end
      checks++; if (ifc.error_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", ifc.error_sticky); end
    end
  endtask

  task automatic test_ready_up();
    rst = 1'b0; ifc.ttc_ready = 1'b1; ifc.fifo_fill = 12'd0;
    tick();
    checks++; if (ifc.tts_state !== C_DISC) begin errors++; $display("FAIL up_cycle1_state: got %b want %b", ifc.tts_state, C_DISC); end
    checks++; if (ifc.tts_changed !== 1'b0) begin errors++; $display("FAIL up_cycle1_changed: got %b want 0", ifc.tts_changed); end
    tick();
    checks++; if (ifc.tts_state !== C_READY) begin errors++; $display("FAIL up_cycle2_state: got %b want %b", ifc.tts_state, C_READY); end
    checks++; if (ifc.tts_changed !== 1'b1) begin errors++; $display("FAIL up_cycle2_changed: got %b want 1", ifc.tts_changed); end
    tick();
    checks++; if (ifc.tts_changed !== 1'b0) begin errors++; $display("FAIL up_pulse_width: got %b want 0", ifc.tts_changed); end
    idle(20);
  endtask

  task automatic test_warn_hysteresis();
    ifc.fifo_fill = 12'd2047; idle(2);
    checks++; if (ifc.tts_state !== C_READY) begin errors++; $display("FAIL warn_below_on: got %b want %b", ifc.tts_state, C_READY); end
    ifc.fifo_fill = 12'd2048; idle(2);
    checks++; if (ifc.tts_state !== C_WARN) begin errors++; $display("FAIL warn_at_on: got %b want %b", ifc.tts_state, C_WARN); end
    checks++; if (ifc.tts_changed !== 1'b1) begin errors++; $display("FAIL warn_changed: got %b want 1", ifc.tts_changed); end
    ifc.fifo_fill = 12'd1600; idle(5);
    checks++; if (ifc.tts_state !== C_WARN) begin errors++; $display("FAIL warn_hold_band: got %b want %b", ifc.tts_state, C_WARN); end
    ifc.fifo_fill = 12'd1535; idle(10);
    checks++; if (ifc.tts_state !== C_WARN) begin errors++; $display("FAIL warn_dwell_hold: got %b want %b", ifc.tts_state, C_WARN); end
    tick();
    checks++; if (ifc.tts_state !== C_READY) begin errors++; $display("FAIL warn_dwell_release: got %b want %b", ifc.tts_state, C_READY); end
    idle(20);
  endtask

  task automatic test_busy_hysteresis();
    ifc.fifo_fill = 12'd3584; idle(2);
    checks++; if (ifc.tts_state !== C_BUSY) begin errors++; $display("FAIL busy_at_on: got %b want %b", ifc.tts_state, C_BUSY); end
    ifc.fifo_fill = 12'd3100; idle(20);
    checks++; if (ifc.tts_state !== C_BUSY) begin errors++; $display("FAIL busy_hold_band: got %b want %b", ifc.tts_state, C_BUSY); end
    ifc.fifo_fill = 12'd3071; idle(2);
    checks++; if (ifc.tts_state !== C_WARN) begin errors++; $display("FAIL busy_below_off: got %b want %b", ifc.tts_state, C_WARN); end
    ifc.fifo_fill = 12'd0; idle(15);
    checks++; if (ifc.tts_state !== C_WARN) begin errors++; $display("FAIL busy_dwell_hold: got %b want %b", ifc.tts_state, C_WARN); end
    tick();
    checks++; if (ifc.tts_state !== C_READY) begin errors++; $display("FAIL busy_dwell_release: got %b want %b", ifc.tts_state, C_READY); end
    idle(20);
  endtask

  task automatic test_error();
    ifc.fifo_fill = 12'd3584; idle(2);
    checks++; if (ifc.tts_state !== C_BUSY) begin errors++; $display("FAIL err_pre_busy: got %b want %b", ifc.tts_state, C_BUSY); end
    ifc.fatal_error = 1'b1; tick(); ifc.fatal_error = 1'b0; tick();
    checks++; if (ifc.tts_state !== C_ERROR) begin errors++; $display("FAIL err_preempt: got %b want %b", ifc.tts_state, C_ERROR); end
    checks++; if (ifc.error_sticky !== 1'b1) begin errors++; $display("FAIL err_sticky_set: got %b want 1", ifc.error_sticky); end
    ifc.fatal_error = 1'b1; ifc.error_clear = 1'b1; tick(); ifc.error_clear = 1'b0; idle(3);
    checks++; if (ifc.tts_state !== C_ERROR) begin errors++; $display("FAIL err_set_wins: got %b want %b", ifc.tts_state, C_ERROR); end
    checks++; if (ifc.error_sticky !== 1'b1) begin errors++; $display("FAIL err_set_wins_sticky: got %b want 1", ifc.error_sticky); end
    ifc.fatal_error = 1'b0; ifc.fifo_fill = 12'd0; idle(20);
    checks++; if (ifc.tts_state !== C_ERROR) begin errors++; $display("FAIL err_sticky_hold: got %b want %b", ifc.tts_state, C_ERROR); end
    ifc.error_clear = 1'b1; tick(); ifc.error_clear = 1'b0; tick();
    checks++; if (ifc.tts_state !== C_READY) begin errors++; $display("FAIL err_clear_expired: got %b want %b", ifc.tts_state, C_READY); end
    checks++; if (ifc.error_sticky !== 1'b0) begin errors++; $display("FAIL err_sticky_clear: got %b want 0", ifc.error_sticky); end
    idle(20);
    ifc.fatal_error = 1'b1; tick(); ifc.fatal_error = 1'b0; tick();
    ifc.error_clear = 1'b1; tick(); ifc.error_clear = 1'b0; tick();
    checks++; if (ifc.error_sticky !== 1'b0) begin errors++; $display("FAIL err_clear_early_sticky: got %b want 0", ifc.error_sticky); end
    idle(13);
    checks++; if (ifc.tts_state !== C_ERROR) begin errors++; $display("FAIL err_clear_dwell_hold: got %b want %b", ifc.tts_state, C_ERROR); end
    tick();
    checks++; if (ifc.tts_state !== C_READY) begin errors++; $display("FAIL err_clear_dwell_release: got %b want %b", ifc.tts_state, C_READY); end
    idle(20);
  endtask

  task automatic test_oos();
    ifc.sync_lost = 1'b1; tick(); ifc.sync_lost = 1'b0; tick();
    checks++; if (ifc.tts_state !== C_OOS) begin errors++; $display("FAIL oos_enter: got %b want %b", ifc.tts_state, C_OOS); end
    idle(20);
    checks++; if (ifc.tts_state !== C_OOS) begin errors++; $display("FAIL oos_latched: got %b want %b", ifc.tts_state, C_OOS); end
    ifc.resync_done = 1'b1; tick(); ifc.resync_done = 1'b0; tick();
    checks++; if (ifc.tts_state !== C_READY) begin errors++; $display("FAIL oos_resync: got %b want %b", ifc.tts_state, C_READY); end
    idle(20);
    ifc.sync_lost = 1'b1; ifc.resync_done = 1'b1; tick();
    ifc.sync_lost = 1'b0; ifc.resync_done = 1'b0; tick();
    checks++; if (ifc.tts_state !== C_OOS) begin errors++; $display("FAIL oos_set_wins: got %b want %b", ifc.tts_state, C_OOS); end
    idle(20);
    checks++; if (ifc.tts_state !== C_OOS) begin errors++; $display("FAIL oos_set_wins_hold: got %b want %b", ifc.tts_state, C_OOS); end
    ifc.ttc_ready = 1'b0; idle(2);
    checks++; if (ifc.tts_state !== C_DISC) begin errors++; $display("FAIL oos_ttc_loss: got %b want %b", ifc.tts_state, C_DISC); end
    ifc.ttc_ready = 1'b1; idle(20);
    checks++; if (ifc.tts_state !== C_OOS) begin errors++; $display("FAIL oos_retained: got %b want %b", ifc.tts_state, C_OOS); end
    ifc.resync_done = 1'b1; tick(); ifc.resync_done = 1'b0; idle(20);
    checks++; if (ifc.tts_state !== C_READY) begin errors++; $display("FAIL oos_final_ready: got %b want %b", ifc.tts_state, C_READY); end
  endtask

  task automatic test_reset_mid();
    ifc.fatal_error = 1'b1; tick(); ifc.fatal_error = 1'b0; tick();
    checks++; if (ifc.tts_state !== C_ERROR) begin errors++; $display("FAIL rstmid_pre_error: got %b want %b", ifc.tts_state, C_ERROR); end
    rst = 1'b1; tick();
    checks++; if (ifc.tts_state !== C_DISC) begin errors++; $display("FAIL rstmid_state: got %b want %b", ifc.tts_state, C_DISC); end
    checks++; if (ifc.error_sticky !== 1'b0) begin errors++; $display("FAIL rstmid_sticky: got %b want 0", ifc.error_sticky); end
    checks++; if (ifc.tts_changed !== 1'b0) begin errors++; $display("FAIL rstmid_changed: got %b want 0", ifc.tts_changed); end
    rst = 1'b0; tick();
    checks++; if (ifc.tts_state !== C_DISC) begin errors++; $display("FAIL rstmid_release_state: got %b want %b", ifc.tts_state, C_DISC); end
    checks++; if (ifc.tts_changed !== 1'b0) begin errors++; $display("FAIL rstmid_release_changed: got %b want 0", ifc.tts_changed); end
    tick();
    checks++; if (ifc.tts_state !== C_READY) begin errors++; $display("FAIL rstmid_ready: got %b want %b", ifc.tts_state, C_READY); end
  endtask

  task automatic test_random();
    int fv;
    fv = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 5))
          0: fv = $urandom_range(0, 4095);
          1: fv = WARN_ON - 1 + $urandom_range(0, 2);
          2: fv = WARN_OFF - 1 + $urandom_range(0, 2);
          3: fv = BUSY_ON - 1 + $urandom_range(0, 2);
          4: fv = BUSY_OFF - 1 + $urandom_range(0, 2);
          5: fv = 4095;
          default: fv = 0;
        endcase
      end
      ifc.fifo_fill   = 12'(fv);
      ifc.ttc_ready   = ($urandom_range(0, 49) != 0);
      ifc.sync_lost   = ($urandom_range(0, 49) == 0);
      ifc.resync_done = ($urandom_range(0, 19) == 0);
      ifc.fatal_error = ($urandom_range(0, 199) == 0);
      ifc.error_clear = ($urandom_range(0, 9) == 0);
      rst             = ($urandom_range(0, 499) == 0);
      tick();
      checks++; if (ifc.tts_state !== m_state) begin errors++; $display("FAIL rnd_state cyc %0d: got %b want %b", cyc, ifc.tts_state, m_state); end
      checks++; if (ifc.tts_changed !== m_changed) begin errors++; $display("FAIL rnd_changed cyc %0d: got %b want %b", cyc, ifc.tts_changed, m_changed); end
      checks++; if (ifc.error_sticky !== m_err) begin errors++; $display("FAIL rnd_sticky cyc %0d: got %b want %b", cyc, ifc.error_sticky, m_err); end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_chg = -1000;
    m_state = C_DISC; m_changed = 1'b0; m_err = 1'b0; m_oos = 1'b0; m_warn = 1'b0; m_busy = 1'b0;
    q_ttc = 1'b0; q_fill = 0; q_sync = 1'b0; q_resync = 1'b0; q_fatal = 1'b0; q_clear = 1'b0;
    test_reset();
    test_ready_up();
    test_warn_hysteresis();
    test_busy_hysteresis();
    test_error();
    test_oos();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
